// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: iterative shift-add multiply, restoring divide.
// Latency: done_o BITS+2 edges after accept (2 for divide special cases); busy_o stalls the pipe meanwhile.
// Backpressure: none accepted; valid_i is only sampled in IDLE, so requests during busy_o are dropped.
// Optional MULDIV_FAST_MUL_EN: single-cycle wide multiplier, multiply ops finish in 2 edges.

package muldiv_unit_pkg;
    localparam logic [4:0] ALUCTRL_ADD    = 5'b00000;
    localparam logic [4:0] ALUCTRL_MUL    = 5'b10000;
    localparam logic [4:0] ALUCTRL_MULH   = 5'b10001;
    localparam logic [4:0] ALUCTRL_MULHSU = 5'b10010;
    localparam logic [4:0] ALUCTRL_MULHU  = 5'b10011;
    localparam logic [4:0] ALUCTRL_DIV    = 5'b10100;
    localparam logic [4:0] ALUCTRL_DIVU   = 5'b10101;
    localparam logic [4:0] ALUCTRL_REM    = 5'b10110;
    localparam logic [4:0] ALUCTRL_REMU   = 5'b10111;
endpackage

module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [4:0]      alu_ctrl_i,
    input  logic [BITS-1:0] rs1_i,
    input  logic [BITS-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [BITS-1:0] result_o
);

    localparam int CW = $clog2(BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t              r_state;
    logic                r_is_mul;
    logic                r_mul_hi;
    logic                r_is_rem;
    logic                r_neg_a;
    logic                r_neg_b;
    logic                r_special;
    logic [BITS-1:0]     r_opnd;
    logic [2*BITS-1:0]   r_acc;
    logic [BITS-1:0]     r_rem;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [BITS-1:0]     r_result;

    logic                w_is_m;
    logic                w_is_mul;
    logic                w_mul_hi;
    logic                w_is_rem;
    logic                w_sgn_a;
    logic                w_sgn_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [BITS-1:0]     w_mag_a;
    logic [BITS-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [BITS-1:0]     w_spec_res;
    logic [BITS:0]       w_mul_sum;
    logic [BITS:0]       w_div_shift;
    logic                w_div_ge;
    logic [BITS-1:0]     w_div_diff;
    logic [BITS-1:0]     w_div_next;
    logic [2*BITS-1:0]   w_prod;
    logic [BITS-1:0]     w_quo;
    logic [BITS-1:0]     w_rmd;
    logic [BITS-1:0]     w_fix_res;

    always_comb begin
        w_is_m   = 1'b1;
        w_is_mul = 1'b0;
        w_mul_hi = 1'b0;
        w_is_rem = 1'b0;
        w_sgn_a  = 1'b0;
        w_sgn_b  = 1'b0;
        case (alu_ctrl_i)
            ALUCTRL_MUL:    begin w_is_mul = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            ALUCTRL_MULH:   begin w_is_mul = 1'b1; w_mul_hi = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            ALUCTRL_MULHSU: begin w_is_mul = 1'b1; w_mul_hi = 1'b1; w_sgn_a = 1'b1; end
            ALUCTRL_MULHU:  begin w_is_mul = 1'b1; w_mul_hi = 1'b1; end
            ALUCTRL_DIV:    begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            ALUCTRL_DIVU:   begin end
            ALUCTRL_REM:    begin w_is_rem = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            ALUCTRL_REMU:   begin w_is_rem = 1'b1; end
            default:        w_is_m = 1'b0;
        endcase
    end

    assign w_neg_a = w_sgn_a & rs1_i[BITS-1];
    assign w_neg_b = w_sgn_b & rs2_i[BITS-1];
    assign w_mag_a = w_neg_a ? -rs1_i : rs1_i;
    assign w_mag_b = w_neg_b ? -rs2_i : rs2_i;

    // Divide corner cases bypass the iteration and are resolved straight from the operands.
    assign w_div_zero = ~w_is_mul & (rs2_i == '0);
    assign w_ovf      = ~w_is_mul & w_sgn_a & (rs1_i == {1'b1, {(BITS-1){1'b0}}}) & (rs2_i == '1);
    assign w_special  = w_div_zero | w_ovf;
    assign w_spec_res = w_div_zero ? (w_is_rem ? rs1_i : '1) : (w_is_rem ? '0 : rs1_i);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*BITS-1:0] w_fast_prod;
    assign w_fast_prod = {{BITS{1'b0}}, w_mag_a} * {{BITS{1'b0}}, w_mag_b};
`endif

    // Multiply: accumulator low half holds the multiplier, consumed LSB first.
    assign w_mul_sum   = {1'b0, r_acc[2*BITS-1:BITS]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

    assign w_div_shift = {r_rem, r_acc[BITS-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[BITS-1:0] - r_opnd;
    assign w_div_next  = w_div_ge ? w_div_diff : w_div_shift[BITS-1:0];

    assign w_prod    = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    assign w_quo     = (r_neg_a ^ r_neg_b) ? -r_acc[BITS-1:0] : r_acc[BITS-1:0];
    assign w_rmd     = r_neg_a ? -r_rem : r_rem;
    assign w_fix_res = r_special ? r_acc[BITS-1:0] :
                       r_is_mul  ? (r_mul_hi ? w_prod[2*BITS-1:BITS] : w_prod[BITS-1:0]) :
                       r_is_rem  ? w_rmd : w_quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_is_mul  <= 1'b0;
            r_mul_hi  <= 1'b0;
            r_is_rem  <= 1'b0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_special <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i && w_is_m) begin
                        r_is_mul <= w_is_mul;
                        r_mul_hi <= w_mul_hi;
                        r_is_rem <= w_is_rem;
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_opnd   <= w_is_mul ? w_mag_a : w_mag_b;
                        if (w_special) begin
                            r_special <= 1'b1;
                            r_acc     <= {{BITS{1'b0}}, w_spec_res};
                            r_state   <= S_FIX;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (w_is_mul) begin
                            r_special <= 1'b0;
                            r_acc     <= w_fast_prod;
                            r_state   <= S_FIX;
`endif
                        end else begin
                            r_special <= 1'b0;
                            r_acc     <= {{BITS{1'b0}}, (w_is_mul ? w_mag_b : w_mag_a)};
                            r_state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_is_mul) begin
                        r_acc <= {w_mul_sum, r_acc[BITS-1:1]};
                    end else begin
                        r_rem             <= w_div_next;
                        r_acc[BITS-1:0]   <= {r_acc[BITS-2:0], w_div_ge};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(BITS-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written handshake/reset sequences, random ops vs arithmetic model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [4:0]  alu_ctrl_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] prev_res = '0;

    muldiv_unit #(.BITS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .alu_ctrl_i (alu_ctrl_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        r  = '0;
        case (op)
            ALUCTRL_MUL:    begin p = sa * sb; r = p[31:0]; end
            ALUCTRL_MULH:   begin p = sa * sb; r = p[63:32]; end
            ALUCTRL_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
            ALUCTRL_MULHU:  begin p = ua * ub; r = p[63:32]; end
            ALUCTRL_DIV:    r = (b == 0) ? 32'hFFFFFFFF :
                                (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'($signed(a) / $signed(b));
            ALUCTRL_DIVU:   r = (b == 0) ? 32'hFFFFFFFF : a / b;
            ALUCTRL_REM:    r = (b == 0) ? a :
                                (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'($signed(a) % $signed(b));
            ALUCTRL_REMU:   r = (b == 0) ? a : a % b;
            default:        r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit is_mul;
        bit sgn_div;
        is_mul  = (op == ALUCTRL_MUL || op == ALUCTRL_MULH || op == ALUCTRL_MULHSU || op == ALUCTRL_MULHU);
        sgn_div = (op == ALUCTRL_DIV || op == ALUCTRL_REM);
        if (is_mul) return MUL_LAT;
        if (b == 0 || (sgn_div && a == 32'h80000000 && b == 32'hFFFFFFFF)) return SPC_LAT;
        return DIV_LAT;
    endfunction

    // Called at a negedge; accept happens at the following posedge. Returns at the negedge where done_o is seen.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input bit poke, input string name);
        int lat;
        valid_i    = 1'b1;
        alu_ctrl_i = op;
        rs1_i      = a;
        rs2_i      = b;
        @(posedge clk);
        @(negedge clk);
        valid_i    = 1'b0;
        alu_ctrl_i = ALUCTRL_ADD;
        rs1_i      = $urandom;
        rs2_i      = $urandom;
        chk({name, "_busy_after_accept"}, {31'b0, busy_o}, 32'd1);
        chk({name, "_done_low"}, {31'b0, done_o}, 32'd0);
        chk({name, "_result_held"}, result_o, prev_res);
        lat = 1;
        while (!done_o && lat < 100) begin
            if (poke && lat == 4) begin
                valid_i    = 1'b1;
                alu_ctrl_i = ALUCTRL_REM;
                rs1_i      = 32'h12345678;
                rs2_i      = 32'h00000003;
            end
            if (poke && lat == 7) valid_i = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!done_o) lat = -1;
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_result"}, result_o, exp);
        chk({name, "_busy_at_done"}, {31'b0, busy_o}, 32'd0);
        prev_res = exp;
    endtask

    initial begin
        int          pulses;
        logic [4:0]  codes [8];
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        codes = '{ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
                  ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};

        tbl[0]  = '{ALUCTRL_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, MUL_LAT};
        tbl[1]  = '{ALUCTRL_MULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, MUL_LAT};
        tbl[2]  = '{ALUCTRL_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        tbl[3]  = '{ALUCTRL_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
        tbl[4]  = '{ALUCTRL_MUL,    32'd1234,     32'd5678,     32'h006AE9BC, MUL_LAT};
        tbl[5]  = '{ALUCTRL_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT};
        tbl[6]  = '{ALUCTRL_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT};
        tbl[7]  = '{ALUCTRL_DIVU,   32'h80000000, 32'h00000003, 32'h2AAAAAAA, DIV_LAT};
        tbl[8]  = '{ALUCTRL_REMU,   32'h80000000, 32'h00000003, 32'h00000002, DIV_LAT};
        tbl[9]  = '{ALUCTRL_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT};
        tbl[10] = '{ALUCTRL_REMU,   32'd5,        32'd0,        32'd5,        SPC_LAT};
        tbl[11] = '{ALUCTRL_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT};
        tbl[12] = '{ALUCTRL_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPC_LAT};
        tbl[13] = '{ALUCTRL_DIV,    32'h80000000, 32'h00000001, 32'h80000000, DIV_LAT};

        rst_n      = 1'b0;
        valid_i    = 1'b0;
        alu_ctrl_i = ALUCTRL_ADD;
        rs1_i      = '0;
        rs2_i      = '0;
        #3;
        chk("reset_busy", {31'b0, busy_o}, 32'd0);
        chk("reset_done", {31'b0, done_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 1'b0, $sformatf("tbl%0d", i));
        end

        // Non-M code must not be accepted.
        valid_i    = 1'b1;
        alu_ctrl_i = ALUCTRL_ADD;
        rs1_i      = 32'd9;
        rs2_i      = 32'd3;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy_o || done_o) pulses++;
        end
        valid_i = 1'b0;
        chk("add_ignored", 32'(pulses), 32'd0);
        chk("add_result_held", result_o, prev_res);

        // Request during busy is dropped; back-to-back accept in the done cycle.
        do_op(ALUCTRL_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1, "busy_poke");
        do_op(ALUCTRL_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, 1'b0, "back2back");

        // Reset in the middle of a divide.
        valid_i    = 1'b1;
        alu_ctrl_i = ALUCTRL_DIVU;
        rs1_i      = 32'd100;
        rs2_i      = 32'd7;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'b0, busy_o}, 32'd0);
        chk("midreset_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o || busy_o) pulses++;
        end
        chk("midreset_no_done", 32'(pulses), 32'd0);
        prev_res = '0;

        for (int i = 0; i < 250; i++) begin
            op = codes[$urandom_range(0, 7)];
            case ($urandom_range(0, 9))
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2:       begin a = 32'($signed(8'($urandom))); b = 32'($signed(4'($urandom))); end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            do_op(op, a, b, ref_res(op, a, b), ref_lat(op, a, b), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M execute unit. It sits directly downstream of the control unit, beside the single-cycle ALU.
- Consumes the 5-bit ALU control code plus both register operands. Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively.
- Returns a registered result with a done pulse. busy_o stalls the pipeline.

Parameters:
- BITS, 32, operand and result width; iteration count of the multiply and divide loops.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  request strobe; sampled only in IDLE
- alu_ctrl_i  input  5  ALU control code from the control unit; decoded against the shared ALUCTRL_MUL..ALUCTRL_REMU constants
- rs1_i  input  BITS  operand A (dividend / multiplicand)
- rs2_i  input  BITS  operand B (divisor / multiplier)
- busy_o  output  1  high from the accepting edge until the edge that raises done_o
- done_o  output  1  one-cycle result-valid pulse
- result_o  output  BITS  result; held until the next done_o

Behaviour:
- Reset values: state=IDLE, busy_o=0, done_o=0, result_o=0, all internal registers cleared. Reset mid-operation aborts the operation; no done_o is produced.
- Accept: an edge with state==IDLE, valid_i=1 and alu_ctrl_i in the 8 M-codes. That edge latches the op, the operand magnitudes, the sign flags and counter=0, and sets busy_o=1.
  - valid_i with a non-M code is ignored.
  - valid_i while busy_o=1 is ignored; operands are not re-sampled.
- States:
  - IDLE -> CALC on a normal accept.
  - IDLE -> FIX on a special case (see below).
  - CALC -> FIX after BITS iterations (counter==BITS-1).
  - FIX -> IDLE unconditionally.
- FIX edge: writes result_o, sets done_o=1, clears busy_o. done_o drops on the next edge.
- Latency:
  - Normal ops: done_o high BITS+2 edges after the accepting edge (34 for BITS=32).
  - Special cases: done_o high 2 edges after the accepting edge.
- Back-to-back: a new accept is legal in the cycle done_o is high, since state is IDLE.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - The datapath operates on magnitudes. FIX applies two's-complement negation:
    - product: when the sign flags differ;
    - quotient: when the sign flags differ;
    - remainder: takes the dividend's sign.
- Multiply: shift-add over a 2*BITS accumulator, one multiplier bit per CALC cycle.
  - MUL returns the low BITS of the product.
  - MULH, MULHSU and MULHU return the high BITS.
- Divide: restoring division, one quotient bit per CALC cycle, BITS+1-bit partial remainder.
- Special cases, decided at accept and routed straight to FIX:
  - Divisor==0: DIV/DIVU quotient = all ones; REM/REMU result = rs1 unchanged.
  - Signed overflow (rs1 = 0x80000000, rs2 = -1): DIV result = 0x80000000; REM result = 0.
- busy_o is the stall request to the hazard logic. The pipeline must hold operands stable only for the accepting cycle.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: the multiply ops compute the full 2*BITS product combinationally at accept, register it, and go IDLE -> FIX. done_o is high 2 edges after accept. Divide behaviour is unchanged.
- Undefined: multiply uses the iterative shift-add path with BITS+2 latency, and no wide multiplier is inferred.

Test Plan:
- Reset mid-CALC:
  - Stimulus: accept DIVU 100/7, assert rst_n=0 at edge 10, release, wait 40 cycles.
  - Response: done_o never pulses; busy_o=0 and result_o=0 immediately on reset.
- Multiply variants, sampling done_o at accept+34:
  - MUL 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFE.
  - MULH -2*3 -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 0x80000000/3 -> 0x2AAAAAAA.
  - REMU 0x80000000/3 -> 0x00000002.
  - Each done_o at accept+34.
- Special cases, done_o at accept+2:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Handshake:
  - valid_i with ALUCTRL_ADD -> no accept, busy_o stays 0.
  - Second valid_i during busy -> ignored; the first result is intact.
  - New accept in the done_o cycle -> second done_o exactly 34 edges later.
- With MULDIV_FAST_MUL_EN defined: MUL 1234*5678 -> 7006652 (0x006AE9BC), done_o at accept+2. DIV timing is still 34.
